// File: rtl/lcd_key_bus_scheduler_if.sv
// Signals exchanged between the bus scheduler, the LCD engine, the row buffer and the
// keyboard pins. The scheduler connects through the master modport.
interface lcd_key_bus_scheduler_if #(
  parameter int NCOLS = 9
);
  logic             lcd_busy;
  logic             lcd_run;
  logic             bus_oe;
  logic [NCOLS-1:0] key_col_n;
  logic [7:0]       key_row_n;
  logic             event_strobe;
  logic [3:0]       event_col;
  logic [7:0]       event_rows;
  logic             drain_timeout;

  modport master (
    input  lcd_busy, key_row_n,
    output lcd_run, bus_oe, key_col_n, event_strobe, event_col, event_rows, drain_timeout
  );

  modport slave (
    output lcd_busy, key_row_n,
    input  lcd_run, bus_oe, key_col_n, event_strobe, event_col, event_rows, drain_timeout
  );
endinterface

// File: rtl/lcd_key_bus_scheduler.sv
// Time-shares the 8-bit data bus between LCD refresh and keyboard scanning: pause LCD,
// drain, turn the bus around, strobe one column, debounce its rows, hand the bus back.
module lcd_key_bus_scheduler #(
  parameter int NCOLS         = 9,
  parameter int SCAN_PERIOD   = 48000,
  parameter int SETTLE        = 500,
  parameter int GUARD         = 4,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input logic                     clk,
  input logic                     reset_n,
  lcd_key_bus_scheduler_if.master bus
);
  localparam int MAX_A = (SCAN_PERIOD > SETTLE) ? SCAN_PERIOD : SETTLE;
  localparam int MAX_B = (GUARD > DRAIN_TIMEOUT) ? GUARD : DRAIN_TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       COL_LAST    = 4'(NCOLS - 1);
  localparam logic [NCOLS-1:0] COL_ONE     = NCOLS'(1);

  typedef enum logic [2:0] {RUN, DRAIN, TURN, DRIVE, SAMPLE, RESTORE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       col_reg, col_next;
  logic             lcd_run_reg, lcd_run_next;
  logic             bus_oe_reg, bus_oe_next;
  logic [NCOLS-1:0] key_col_n_reg, key_col_n_next;
  logic             event_strobe_reg, event_strobe_next;
  logic [3:0]       event_col_reg, event_col_next;
  logic [7:0]       event_rows_reg, event_rows_next;
  logic             drain_timeout_reg, drain_timeout_next;

  logic [7:0] raw;
  logic [7:0] deb_all  [NCOLS];
  logic [7:0] prev_all [NCOLS];
  logic       sample_en;
  logic       deb_update;

  assign raw        = ~bus.key_row_n;
  assign sample_en  = (state_reg == SAMPLE);
  // A new state is accepted only when two consecutive scans of the column agree.
  assign deb_update = (raw == prev_all[col_reg]) && (raw != deb_all[col_reg]);

  genvar gi;
  generate
    for (gi = 0; gi < NCOLS; gi++) begin : g_col
      logic [7:0] deb_reg;
      logic [7:0] prev_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_reg  <= '0;
          prev_reg <= '0;
        end else if (sample_en && (col_reg == 4'(gi))) begin
          prev_reg <= raw;
          if (deb_update) begin
            deb_reg <= raw;
          end
        end
      end

      assign deb_all[gi]  = deb_reg;
      assign prev_all[gi] = prev_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= RUN;
      cnt_reg           <= '0;
      col_reg           <= '0;
      lcd_run_reg       <= 1'b1;
      bus_oe_reg        <= 1'b1;
      key_col_n_reg     <= '1;
      event_strobe_reg  <= 1'b0;
      event_col_reg     <= '0;
      event_rows_reg    <= '0;
      drain_timeout_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      col_reg           <= col_next;
      lcd_run_reg       <= lcd_run_next;
      bus_oe_reg        <= bus_oe_next;
      key_col_n_reg     <= key_col_n_next;
      event_strobe_reg  <= event_strobe_next;
      event_col_reg     <= event_col_next;
      event_rows_reg    <= event_rows_next;
      drain_timeout_reg <= drain_timeout_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    col_next           = col_reg;
    lcd_run_next       = lcd_run_reg;
    bus_oe_next        = bus_oe_reg;
    key_col_n_next     = key_col_n_reg;
    event_strobe_next  = 1'b0;
    event_col_next     = event_col_reg;
    event_rows_next    = event_rows_reg;
    drain_timeout_next = 1'b0;

    case (state_reg)
      RUN: begin
        if (cnt_reg == RUN_LAST) begin
          cnt_next     = '0;
          lcd_run_next = 1'b0;
          state_next   = DRAIN;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DRAIN: begin
        // The bus is released only once the LCD is seen idle while paused.
        if (!bus.lcd_busy) begin
          cnt_next    = '0;
          bus_oe_next = 1'b0;
          state_next  = TURN;
        end else if (cnt_reg == DRAIN_LAST) begin
          cnt_next           = '0;
          drain_timeout_next = 1'b1;
          lcd_run_next       = 1'b1;
          state_next         = RUN;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      TURN: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next       = '0;
          key_col_n_next = ~(COL_ONE << col_reg);
          state_next     = DRIVE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DRIVE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      SAMPLE: begin
        if (deb_update) begin
          event_strobe_next = 1'b1;
          event_col_next    = col_reg;
          event_rows_next   = raw;
        end
        key_col_n_next = '1;
        state_next     = RESTORE;
      end
      RESTORE: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next     = '0;
          bus_oe_next  = 1'b1;
          lcd_run_next = 1'b1;
          col_next     = (col_reg == COL_LAST) ? 4'd0 : col_reg + 4'd1;
          state_next   = RUN;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign bus.lcd_run       = lcd_run_reg;
  assign bus.bus_oe        = bus_oe_reg;
  assign bus.key_col_n     = key_col_n_reg;
  assign bus.event_strobe  = event_strobe_reg;
  assign bus.event_col     = event_col_reg;
  assign bus.event_rows    = event_rows_reg;
  assign bus.drain_timeout = drain_timeout_reg;
endmodule

// File: tb/tb_lcd_key_bus_scheduler.sv
// Bench for lcd_key_bus_scheduler: a slot-timeline model checked every cycle, plus
// directed slots with hand-computed expectations.
module tb_lcd_key_bus_scheduler;
  localparam int NC = 9;
  localparam int SP = 20;
  localparam int ST = 5;
  localparam int GD = 2;
  localparam int DT = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lcd_key_bus_scheduler_if #(.NCOLS(NC)) bus ();

  lcd_key_bus_scheduler #(
    .NCOLS(NC), .SCAN_PERIOD(SP), .SETTLE(ST), .GUARD(GD), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] col_pat(input int c);
    col_pat = ~(9'd1 << c);
  endfunction

  // Keyboard matrix: rows pulled low only while their column is driven low.
  logic [7:0] key_mat [NC];
  initial begin
    logic [7:0] r;
    for (int i = 0; i < NC; i++) key_mat[i] = 8'h00;
    bus.key_row_n = 8'hFF;
    forever begin
      @(negedge clk);
      r = 8'h00;
      for (int c = 0; c < NC; c++) if (bus.key_col_n[c] === 1'b0) r = r | key_mat[c];
      bus.key_row_n = ~r;
    end
  end

  // Model: position m_t within the current slot, bus fall time m_fall (-1 = not yet).
  int         m_t, m_fall, m_col;
  logic [7:0] m_deb [NC];
  logic [7:0] m_prev [NC];
  logic       m_ev, m_to;
  logic [3:0] m_ev_col;
  logic [7:0] m_ev_rows;

  task automatic model_reset();
    m_t = 0; m_fall = -1; m_col = 0;
    m_ev = 0; m_to = 0; m_ev_col = 4'd0; m_ev_rows = 8'h00;
    for (int i = 0; i < NC; i++) begin m_deb[i] = 8'h00; m_prev[i] = 8'h00; end
  endtask

  task automatic model_step(input logic busy, input logic [7:0] rows);
    logic [7:0] raw;
    m_ev = 0; m_to = 0;
    if (m_fall < 0 && m_t >= SP) begin
      if (!busy) m_fall = m_t + 1;
      else if (m_t - SP == DT - 1) begin
        m_to = 1; m_t = 0;
        return;
      end
    end
    if (m_fall >= 0 && m_t == m_fall + GD + ST) begin
      raw = ~rows;
      if (raw == m_prev[m_col] && raw != m_deb[m_col]) begin
        m_deb[m_col] = raw; m_ev = 1; m_ev_col = 4'(m_col); m_ev_rows = raw;
      end
      m_prev[m_col] = raw;
    end
    if (m_fall >= 0 && m_t == m_fall + 2 * GD + ST) begin
      m_t = 0; m_fall = -1; m_col = (m_col + 1) % NC;
    end else begin
      m_t++;
    end
  endtask

  logic       s_busy;
  logic [7:0] s_rows;
  logic [8:0] e_cols;
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      s_busy = bus.lcd_busy;
      s_rows = bus.key_row_n;
      if (!reset_n) model_reset();
      else model_step(s_busy, s_rows);
      #1;
      e_cols = (m_fall >= 0 && m_t >= m_fall + GD && m_t <= m_fall + GD + ST) ? col_pat(m_col) : 9'h1FF;
      chk("lcd_run", bus.lcd_run, (m_t < SP) ? 1 : 0);
      chk("bus_oe", bus.bus_oe, (m_fall < 0) ? 1 : 0);
      chk("key_col_n", bus.key_col_n, e_cols);
      chk("drain_timeout", bus.drain_timeout, m_to);
      chk("event_strobe", bus.event_strobe, m_ev);
      chk("event_col", bus.event_col, m_ev_col);
      chk("event_rows", bus.event_rows, m_ev_rows);
      n_checks++;
      assert (!(bus.bus_oe === 1'b1 && bus.key_col_n !== 9'h1FF)) else begin
        n_err++;
        $display("FAIL bus_contention: bus_oe=%b key_col_n=0x%03h required col all ones", bus.bus_oe, bus.key_col_n);
      end
    end
  end

  // Per-slot observations, measured in cycles from the lcd_run fall (cycle 0).
  int         exp_col, busy_tail;
  int         slot_oe_at, slot_oe_low, slot_to_at, slot_ev_n;
  logic [8:0] slot_cols;
  logic [3:0] slot_ev_col;
  logic [7:0] slot_ev_rows;

  task automatic do_slot(input int busy_cyc);
    int n = 0;
    bit done = 0;
    while (bus.lcd_run !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
      bus.lcd_busy = (n < busy_tail);
    end
    busy_tail = 0;
    chk("run_period", n, SP);
    slot_oe_at = -1; slot_oe_low = 0; slot_to_at = -1; slot_ev_n = 0;
    slot_cols = 9'h1FF; slot_ev_col = 4'd0; slot_ev_rows = 8'h00;
    for (int c = 0; c < 60; c++) begin
      bus.lcd_busy = (c < busy_cyc);
      if (bus.bus_oe === 1'b0) begin
        slot_oe_low++;
        if (slot_oe_at < 0) slot_oe_at = c;
      end
      slot_cols = slot_cols & bus.key_col_n;
      if (bus.drain_timeout === 1'b1 && slot_to_at < 0) slot_to_at = c;
      if (bus.event_strobe === 1'b1) begin
        slot_ev_n++; slot_ev_col = bus.event_col; slot_ev_rows = bus.event_rows;
      end
      if (c > 0 && bus.lcd_run === 1'b1) begin
        done = 1;
        busy_tail = (busy_cyc > c) ? busy_cyc - c : 0;
        break;
      end
      @(negedge clk);
    end
    chk("slot_end", done, 1);
    $display("slot: col_n=0x%03h oe_at=%0d oe_low=%0d timeout_at=%0d events=%0d col=%0d rows=0x%02h",
             slot_cols, slot_oe_at, slot_oe_low, slot_to_at, slot_ev_n, slot_ev_col, slot_ev_rows);
  endtask

  // Run normal slots until target_col has been scanned nscans times; only the final
  // scan may carry an event, which the caller checks.
  task automatic slots_until(input int target, input int nscans);
    int seen = 0;
    for (int s = 0; s < 40 && seen < nscans; s++) begin
      do_slot(0);
      chk("slot_col", slot_cols, col_pat(exp_col));
      chk("slot_oe_low", slot_oe_low, 2 * GD + ST + 1);
      chk("slot_oe_at", slot_oe_at, 1);
      if (exp_col == target) seen++;
      if (!(exp_col == target && seen == nscans)) chk("no_event", slot_ev_n, 0);
      exp_col = (exp_col + 1) % NC;
    end
    chk("scan_reached", seen, nscans);
  endtask

  task automatic chk_reset_values();
    chk("rst_lcd_run", bus.lcd_run, 1);
    chk("rst_bus_oe", bus.bus_oe, 1);
    chk("rst_key_col_n", bus.key_col_n, 9'h1FF);
    chk("rst_event_strobe", bus.event_strobe, 0);
    chk("rst_event_col", bus.event_col, 0);
    chk("rst_event_rows", bus.event_rows, 0);
    chk("rst_drain_timeout", bus.drain_timeout, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    bus.lcd_busy = 1'b0;
    exp_col = 0;
    busy_tail = 0;
    repeat (2) @(negedge clk);
    chk_reset_values();
    reset_n = 1'b1;

    // Idle scanning: columns walk 0..8 then wrap to 0, no events.
    slots_until(0, 2);
    chk("idle_no_event", slot_ev_n, 0);

    // Column 3 rows 0x5A: event only on the second scan, then release.
    key_mat[3] = 8'h5A;
    slots_until(3, 2);
    chk("press_ev_n", slot_ev_n, 1);
    chk("press_ev_col", slot_ev_col, 3);
    chk("press_ev_rows", slot_ev_rows, 8'h5A);
    key_mat[3] = 8'h00;
    slots_until(3, 2);
    chk("release_ev_n", slot_ev_n, 1);
    chk("release_ev_col", slot_ev_col, 3);
    chk("release_ev_rows", slot_ev_rows, 8'h00);

    // Single-scan glitch on column 0 never produces an event.
    slots_until(8, 1);
    key_mat[0] = 8'h01;
    slots_until(0, 1);
    chk("glitch_ev_n_a", slot_ev_n, 0);
    key_mat[0] = 8'h00;
    slots_until(0, 1);
    chk("glitch_ev_n_b", slot_ev_n, 0);
    slots_until(0, 1);
    chk("glitch_ev_n_c", slot_ev_n, 0);

    // LCD stays busy 10 cycles: slot aborted at cycle 8, same column retried.
    do_slot(10);
    chk("timeout_at", slot_to_at, DT);
    chk("timeout_oe_low", slot_oe_low, 0);
    chk("timeout_cols", slot_cols, 9'h1FF);
    do_slot(0);
    chk("retry_col", slot_cols, col_pat(exp_col));
    exp_col = (exp_col + 1) % NC;

    // LCD idle after 3 busy cycles: bus released the cycle after busy is seen low.
    do_slot(3);
    chk("late_oe_at", slot_oe_at, 4);
    chk("late_oe_low", slot_oe_low, 2 * GD + ST + 1);
    chk("late_col", slot_cols, col_pat(exp_col));
    exp_col = (exp_col + 1) % NC;

    // Reset mid-DRIVE: bus returns to the LCD at once, scan restarts at column 0.
    n = 0;
    while (bus.key_col_n === 9'h1FF && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drive_reached", (bus.key_col_n != 9'h1FF), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);
    reset_n = 1'b1;
    exp_col = 0;
    do_slot(0);
    chk("restart_col", slot_cols, 9'h1FE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/lcd_key_bus_scheduler.md
Name: lcd_key_bus_scheduler

Overview:
- Time-shares the 8-bit data bus between the LCD refresh engine and the keyboard matrix. The bus carries LCD data out and keyboard rows in; the LCD chip selects double as keyboard columns.
- Periodically pauses the LCD controller and waits for it to go idle, then turns the bus around and strobes one keyboard column low.
- Samples and debounces the rows, reports changes, then hands the bus back to the LCD.
- Sits in top between the lcd instance (frame_strobe/busy), the tristate SB_IO row buffer (OUTPUT_ENABLE) and the column pins.

Parameters:
- NCOLS, 9, number of keyboard columns scanned (0..NCOLS-1).
- SCAN_PERIOD, 48000, clk cycles of LCD ownership between column slots (1 ms at 48 MHz).
- SETTLE, 500, cycles a column is held low before rows are sampled.
- GUARD, 4, bus turnaround dead cycles (bus released before column drive, and after column release).
- DRAIN_TIMEOUT, 4096, maximum cycles to wait for the LCD to go idle.

Ports:
- clk  in  1  system clock (48 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- lcd_busy  in  1  high while the LCD controller is mid-transfer.
- lcd_run  out  1  drives lcd frame_strobe; 1 = LCD may refresh.
- bus_oe  out  1  data-bus output enable to SB_IO; 1 = LCD drives the bus.
- key_col_n  out  NCOLS  column drive, active-low; all ones when idle.
- key_row_n  in  8  raw row inputs, pulled up, active-low.
- event_strobe  out  1  one-cycle pulse: debounced column state changed.
- event_col  out  4  column index of the event.
- event_rows  out  8  new debounced state of that column, 1 = pressed.
- drain_timeout  out  1  one-cycle pulse when a slot is aborted.

Behaviour:
- Reset values (asynchronous): lcd_run=1, bus_oe=1, key_col_n=all 1, event_strobe=0, event_col=0, event_rows=0, drain_timeout=0, state=RUN, column index=0, counters=0, debounced and previous-raw arrays all 0.
- Asserting reset mid-scan returns the bus to the LCD immediately.
- RUN: lcd_run=1, bus_oe=1. The period counter increments each cycle. At SCAN_PERIOD-1: clear the counter, set lcd_run=0, go to DRAIN.
- DRAIN: lcd_run=0, bus_oe=1.
  - lcd_busy sampled low -> clear the counter, go to TURN.
  - Counter reaches DRAIN_TIMEOUT-1 with lcd_busy still high -> pulse drain_timeout, set lcd_run=1, go to RUN. The column index is unchanged, so the same column is retried next slot.
- TURN: bus_oe=0, key_col_n all 1, for GUARD cycles. Then drive key_col_n[col]=0 and go to DRIVE.
- DRIVE: hold the column low for SETTLE cycles, then go to SAMPLE.
- SAMPLE (1 cycle): raw = ~key_row_n.
  - Debounce: if raw == prev_raw[col] and raw != deb[col], set deb[col]=raw and, on the next cycle, pulse event_strobe with event_col=col, event_rows=raw.
  - prev_raw[col] <= raw unconditionally.
  - A change therefore needs two consecutive identical scans of that column.
  - Set key_col_n all 1 and go to RESTORE.
- RESTORE: GUARD cycles with bus_oe=0 and columns high. Then set bus_oe=1, lcd_run=1, and advance col (wrap NCOLS-1 -> 0). Go to RUN.
- Ordering invariants:
  - bus_oe and any key_col_n low are never both asserted.
  - bus_oe only falls after lcd_busy has been seen low with lcd_run=0.
  - lcd_run only rises in the same cycle bus_oe rises, or on timeout abort.
- lcd_busy rising during TURN/DRIVE/RESTORE is ignored: lcd_run is 0, so the LCD must not start.
- Counters are sized to hold the largest parameter. No counter wraps except the column index.
- Slot length, from lcd_run fall with the LCD already idle: 1 + GUARD + SETTLE + 1 + GUARD cycles, ±1.

Test Plan:
- Bench parameters SCAN_PERIOD=20, SETTLE=5, GUARD=2, DRAIN_TIMEOUT=8, NCOLS=9, no keys pressed, lcd_busy=0.
  - Required: lcd_run falls every slot; bus_oe=0 for 2+5+1+2 ±1 cycles; key_col_n walks 0x1FE, 0x1FD, …, 0x0FF, then wraps to 0x1FE.
  - Required: no event_strobe.
- Rows 0x5A (key_row_n=0xA5) present only while column 3 is low.
  - Required: no event on the first scan of column 3; on the second scan, event_strobe with event_col=3, event_rows=0x5A.
  - Release the keys: after two scans, event_rows=0x00.
- Single-scan glitch: 0x01 on column 0 for one scan only -> no event.
- lcd_busy held high for 10 cycles after lcd_run falls.
  - Required: drain_timeout pulses at cycle 8; bus_oe stays 1 throughout; the same column is scanned in the next slot.
- lcd_busy low 3 cycles after lcd_run falls.
  - Required: bus_oe falls exactly after busy is seen low; at no cycle are bus_oe=1 and key_col_n≠all-ones simultaneously (checked by assertion).
- reset_n pulsed low during DRIVE.
  - Required: lcd_run=1, bus_oe=1, key_col_n=0x1FF asynchronously; the scan restarts at column 0.
